// File: rtl/decoder3x8_strobe_if.sv
`default_nettype none
// =============================================================================
// Module   : decoder3x8_strobe_if
// Purpose  : Code-stream handshake and decoded-output bundle for decoder3x8_strobe
// Revision : 1.0 - initial release
// =============================================================================
interface decoder3x8_strobe_if #(
    parameter int DEPTH = 4
);
    logic [2:0]              D;
    logic                    en;
    logic                    valid;
    logic                    ready;
    logic [7:0]              Y;
    logic                    strobe;
    logic                    busy;
    logic [$clog2(DEPTH):0]  level;

    modport master (output D, en, valid, input ready, Y, strobe, busy, level);
    modport slave  (input D, en, valid, output ready, Y, strobe, busy, level);
endinterface
`default_nettype wire

// File: rtl/decoder3x8_strobe.sv
`default_nettype none
// =============================================================================
// Module   : decoder3x8_strobe
// Purpose  : FIFO-fed 3-to-8 one-hot decoder, each slot held HOLD cycles + GAP zeros
// Revision : 1.0 - initial release
// =============================================================================
module decoder3x8_strobe #(
    parameter int HOLD  = 4,
    parameter int GAP   = 1,
    parameter int DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    decoder3x8_strobe_if.slave     bus
);
    localparam int c_AW   = $clog2(DEPTH);
    localparam int c_MAXV = (HOLD > GAP) ? HOLD : GAP;
    localparam int c_CW   = (c_MAXV > 1) ? $clog2(c_MAXV) : 1;
    localparam logic [c_CW-1:0] c_HOLD_LD = c_CW'(HOLD - 1);
    localparam logic [c_CW-1:0] c_GAP_LD  = c_CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [c_AW:0]   c_DEPTH   = (c_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    logic [3:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_level;

    state_t          r_state,  w_state_nxt;
    logic [c_CW-1:0] r_cnt,    w_cnt_nxt;
    logic [7:0]      r_y,      w_y_nxt;
    logic            r_strobe, w_strobe_nxt;
    logic            w_pop;

    logic            w_ready;
    logic            w_empty;
    logic            w_push;
    logic [3:0]      w_head;
    logic [7:0]      w_dec;

    // ready looks only at the registered level, so a same-edge pop never raises it
    assign w_ready = (r_level < c_DEPTH);
    assign w_empty = (r_level == '0);
    assign w_push  = bus.valid && w_ready;
    assign w_head  = r_mem[r_rd_ptr];
    assign w_dec   = w_head[3] ? (8'h01 << w_head[2:0]) : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= {bus.en, bus.D};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_y      <= 8'h00;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_y      <= w_y_nxt;
            r_strobe <= w_strobe_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_y_nxt      = r_y;
        w_strobe_nxt = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_y_nxt = 8'h00;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_y_nxt      = w_dec;
                    w_strobe_nxt = 1'b1;
                    w_cnt_nxt    = c_HOLD_LD;
                    w_state_nxt  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (GAP > 0) begin
                    w_y_nxt     = 8'h00;
                    w_cnt_nxt   = c_GAP_LD;
                    w_state_nxt = S_GAP;
                end else if (!w_empty) begin
                    // back-to-back slots with no zero cycle in between
                    w_pop        = 1'b1;
                    w_y_nxt      = w_dec;
                    w_strobe_nxt = 1'b1;
                    w_cnt_nxt    = c_HOLD_LD;
                end else begin
                    w_y_nxt     = 8'h00;
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                w_y_nxt = 8'h00;
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_y_nxt      = w_dec;
                    w_strobe_nxt = 1'b1;
                    w_cnt_nxt    = c_HOLD_LD;
                    w_state_nxt  = S_DRIVE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_y_nxt     = 8'h00;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.ready  = w_ready;
    assign bus.Y      = r_y;
    assign bus.strobe = r_strobe;
    assign bus.busy   = (r_state != S_IDLE) || !w_empty;
    assign bus.level  = r_level;
endmodule
`default_nettype wire

// File: tb/tb_decoder3x8_strobe.sv
`default_nettype none
// =============================================================================
// Module   : tb_decoder3x8_strobe
// Purpose  : Bench for decoder3x8_strobe, GAP=1 and GAP=0 builds against a slot-schedule model
// Revision : 1.0 - initial release
// =============================================================================
module tb_decoder3x8_strobe;
    localparam int HOLD  = 4;
    localparam int DEPTH = 4;
    localparam int NMAX  = 2048;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] d;
    logic       en;
    logic       valid;

    int tests = 0;
    int fails = 0;
    int k     = 0;
    logic acc;

    // model[m]: m=1 is the GAP=1 build, m=0 the GAP=0 build
    int         sp   [2][NMAX];
    int         ss   [2][NMAX];
    logic [3:0] sc   [2][NMAX];
    int         n    [2];
    int         last [2];
    logic       rdy_prev [2];

    decoder3x8_strobe_if #(.DEPTH(DEPTH)) bus1 ();
    decoder3x8_strobe_if #(.DEPTH(DEPTH)) bus0 ();

    assign bus1.D = d;  assign bus1.en = en;  assign bus1.valid = valid;
    assign bus0.D = d;  assign bus0.en = en;  assign bus0.valid = valid;

    decoder3x8_strobe #(.HOLD(HOLD), .GAP(1), .DEPTH(DEPTH)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    decoder3x8_strobe #(.HOLD(HOLD), .GAP(0), .DEPTH(DEPTH)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    always #5 clk = ~clk;

    // Each entry's slot starts at max(push edge + 1, previous start + HOLD + GAP)
    task automatic expect_at(input int m, input int kk, output logic [7:0] y,
                             output logic st, output logic bs, output logic rd,
                             output logic [3:0] lv);
        int g;
        int lvl;
        logic nonidle;
        g = (m == 1) ? 1 : 0;
        y = 8'h00; st = 1'b0; nonidle = 1'b0; lvl = 0;
        for (int i = 0; i < n[m]; i++) begin
            if (ss[m][i] <= kk && kk < ss[m][i] + HOLD) begin
                y = sc[m][i][3] ? 8'(1 << sc[m][i][2:0]) : 8'h00;
                if (kk == ss[m][i]) st = 1'b1;
            end
            if (ss[m][i] <= kk && kk <= ss[m][i] + HOLD + g - 1) nonidle = 1'b1;
            if (sp[m][i] <= kk && ss[m][i] > kk) lvl++;
        end
        bs = nonidle || (lvl > 0);
        rd = (lvl < DEPTH);
        lv = 4'(lvl);
    endtask

    task automatic chk(input string tag, input int m, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d cycle %0d: observed %h expected %h", tag, m, k, obs, exp);
        end
    endtask

    task automatic step();
        logic [7:0] ey;
        logic est, ebs, erd;
        logic [3:0] elv;
        int s;
        int g;
        @(posedge clk);
        k++;
        acc = 1'b0;
        for (int m = 0; m < 2; m++) begin
            g = (m == 1) ? 1 : 0;
            if (rst) begin
                n[m]    = 0;
                last[m] = -1000;
            end else if (valid && rdy_prev[m] && n[m] < NMAX) begin
                s = k + 1;
                if (last[m] + HOLD + g > s) s = last[m] + HOLD + g;
                sp[m][n[m]] = k;
                ss[m][n[m]] = s;
                sc[m][n[m]] = {en, d};
                n[m]++;
                last[m] = s;
                if (m == 1) acc = 1'b1;
            end
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            expect_at(m, k, ey, est, ebs, erd, elv);
            chk("Y",      m, (m == 1) ? bus1.Y : bus0.Y, ey);
            chk("strobe", m, {7'd0, (m == 1) ? bus1.strobe : bus0.strobe}, {7'd0, est});
            chk("busy",   m, {7'd0, (m == 1) ? bus1.busy : bus0.busy}, {7'd0, ebs});
            chk("ready",  m, {7'd0, (m == 1) ? bus1.ready : bus0.ready}, {7'd0, erd});
            chk("level",  m, {5'd0, (m == 1) ? bus1.level : bus0.level}, {4'd0, elv});
            rdy_prev[m] = erd;
        end
    endtask

    initial begin
        int code;
        int guard;
        n[0] = 0; n[1] = 0; last[0] = -1000; last[1] = -1000;
        rdy_prev[0] = 1'b1; rdy_prev[1] = 1'b1;

        // reset held with a valid code present: nothing may be queued
        rst = 1'b1; valid = 1'b1; d = 3'd3; en = 1'b1;
        step(); step();
        rst = 1'b0; valid = 1'b0;
        repeat (3) step();

        // single code
        d = 3'd5; en = 1'b1; valid = 1'b1;
        step();
        valid = 1'b0;
        repeat (8) step();

        // stream 0..7 with valid held high
        code = 0; guard = 0; valid = 1'b1; en = 1'b1;
        while (code < 8 && guard < 200) begin
            d = 3'(code);
            step();
            if (acc) code++;
            guard++;
        end
        tests++;
        assert (code == 8) else begin
            fails++;
            $error("FAIL stream_accept: observed %0d codes expected 8", code);
        end
        valid = 1'b0;
        repeat (45) step();

        // blank slot followed by a real code
        valid = 1'b1; en = 1'b0; d = 3'd7;
        step();
        en = 1'b1; d = 3'd2;
        step();
        valid = 1'b0;
        repeat (14) step();

        // back-to-back pair, shows no zero cycle on the GAP=0 build
        valid = 1'b1; en = 1'b1; d = 3'd1;
        step();
        d = 3'd2;
        step();
        valid = 1'b0;
        repeat (14) step();

        // random traffic with occasional reset
        repeat (600) begin
            valid = ($urandom_range(0, 2) == 0);
            d     = 3'($urandom);
            en    = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; valid = 1'b0;
        repeat (30) step();

        // reset in the second DRIVE cycle of the first of three queued codes
        valid = 1'b1; en = 1'b1;
        d = 3'd6; step();
        d = 3'd1; step();
        d = 3'd4; step();
        d = 3'd3; rst = 1'b1;
        step();
        rst = 1'b0; valid = 1'b0;
        repeat (15) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
